// File: rtl/booth_wallace_mul_pipe_if.sv
// Operand/product channel of the pipelined Booth multiplier.
// Both sides use valid/ready: a beat transfers on a rising edge where valid && ready,
// and the producer holds valid and its payload stable until that edge.
interface booth_wallace_mul_pipe_if #(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_product, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_product, out_tag
  );
endinterface

// File: rtl/booth_wallace_mul_pipe.sv
// Three-stage radix-4 Booth multiplier: S1 Booth select, S2 Wallace 3:2 reduction,
// S3 carry-propagate add. Full 2*WIDTH product, signed or unsigned, with a pass-through tag.
module booth_wallace_mul_pipe #(
  parameter int WIDTH = 24,
  parameter int TAG_W = 4
) (
  input logic                     clk,
  input logic                     rst,
  booth_wallace_mul_pipe_if.slave bus
);
  localparam int EW = WIDTH + 2;
  localparam int PW = 2 * WIDTH;
  localparam int NPP = WIDTH / 2 + 1;
  localparam int NR = NPP + 1;
  // Enough 3:2 levels for the largest legal row count (18 rows at WIDTH=32 needs 6).
  localparam int TREE_LVLS = 8;

  logic             v1, v2, v3;
  logic             load1, load2, load3;
  logic [TAG_W-1:0] tag1, tag2, tag3;
  logic [PW-1:0]    pp_d [NR];
  logic [PW-1:0]    pp_q [NR];
  logic [PW-1:0]    sum_d, carry_d, sum_q, carry_q, prod_q;
  logic [EW-1:0]    a_ext, b_ext;
  logic [PW-1:0]    a_pw;
  logic [EW:0]      b_trip;

  assign load3 = !v3 || bus.out_ready;
  assign load2 = !v2 || load3;
  assign load1 = !v1 || load2;
  assign bus.in_ready = load1;

  assign a_ext  = {{2{bus.in_signed & bus.in_a[WIDTH-1]}}, bus.in_a};
  assign b_ext  = {{2{bus.in_signed & bus.in_b[WIDTH-1]}}, bus.in_b};
  assign a_pw   = {{(PW-EW){a_ext[EW-1]}}, a_ext};
  assign b_trip = {b_ext, 1'b0};

  // Rows 0..NPP-1 are the shifted partial products; row NPP collects the +1 of negated rows.
  always_comb begin
    logic [2:0]    trip;
    logic [PW-1:0] mag;
    for (int i = 0; i < NR; i++) pp_d[i] = '0;
    for (int i = 0; i < NPP; i++) begin
      trip = b_trip[2*i +: 3];
      case (trip)
        3'b001, 3'b010, 3'b101, 3'b110: mag = a_pw;
        3'b011, 3'b100:                 mag = a_pw << 1;
        default:                        mag = '0;
      endcase
      if (trip[2] && trip != 3'b111) begin
        pp_d[i] = (~mag) << (2 * i);
        pp_d[NPP][2*i] = 1'b1;
      end else begin
        pp_d[i] = mag << (2 * i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1   <= 1'b0;
      tag1 <= '0;
      for (int i = 0; i < NR; i++) pp_q[i] <= '0;
    end else begin
      if (load1) v1 <= bus.in_valid;
      if (load1 && bus.in_valid) begin
        pp_q <= pp_d;
        tag1 <= bus.in_tag;
      end
    end
  end

  // Each level groups the live rows in threes through full adders; leftovers pass through.
  always_comb begin
    logic [PW-1:0] t  [NR];
    logic [PW-1:0] nx [NR];
    int n, m, base;
    t = pp_q;
    n = NR;
    for (int lvl = 0; lvl < TREE_LVLS; lvl++) begin
      nx   = '{default: '0};
      m    = 0;
      base = (n / 3) * 3;
      for (int j = 0; j < NR / 3; j++) begin
        if (3 * j + 2 < n) begin
          nx[m]     = t[3*j] ^ t[3*j+1] ^ t[3*j+2];
          nx[m + 1] = ((t[3*j] & t[3*j+1]) | (t[3*j] & t[3*j+2]) | (t[3*j+1] & t[3*j+2])) << 1;
          m = m + 2;
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (i >= base && i < n) begin
          nx[m] = t[i];
          m = m + 1;
        end
      end
      if (n > 2) begin
        t = nx;
        n = m;
      end
    end
    sum_d   = t[0];
    carry_d = t[1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2      <= 1'b0;
      tag2    <= '0;
      sum_q   <= '0;
      carry_q <= '0;
    end else begin
      if (load2) v2 <= v1;
      if (load2 && v1) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
        tag2    <= tag1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v3     <= 1'b0;
      tag3   <= '0;
      prod_q <= '0;
    end else begin
      if (load3) v3 <= v2;
      if (load3 && v2) begin
        prod_q <= sum_q + carry_q;
        tag3   <= tag2;
      end
    end
  end

  assign bus.out_valid   = v3;
  assign bus.out_product = prod_q;
  assign bus.out_tag     = tag3;
endmodule
